// File: rtl/tlut_pkg.sv
// Shared types and default dimensions for the temporal-LUT multiplier array.
package tlut_pkg;

    localparam int unsigned TLUT_DIM_C        = 16;
    localparam int unsigned TLUT_WEIGHT_WIDTH = 8;

    typedef logic [TLUT_WEIGHT_WIDTH-1:0] weight_t;
    typedef weight_t [TLUT_DIM_C-1:0]     weight_vec_t;

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

endpackage

// File: rtl/weight_vec_slot.sv
// Output holding register for one packed weight vector, presented on a valid/ready handshake.
module weight_vec_slot #(
    parameter int unsigned DIM_C        = 16,
    parameter int unsigned WEIGHT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load,
    input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   load_data,
    input  logic                                 load_short,
    output logic                                 slot_free,
    output logic                                 vec_valid,
    input  logic                                 vec_ready,
    output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   vec_data,
    output logic                                 vec_short
);

    logic                               valid_q;
    logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] data_q;
    logic                               short_q;

    // The slot can accept a new vector in the same cycle it is being drained.
    assign slot_free = !valid_q || vec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            short_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            short_q <= load_short;
        end else if (vec_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign vec_valid = valid_q;
    assign vec_data  = data_q;
    assign vec_short = short_q;

endmodule

// File: rtl/weight_stream_packer.sv
// Packs a one-weight-per-beat stream into DIM_C-lane vectors, with one fill buffer
// behind a single output slot so input keeps flowing while a vector waits.
module weight_stream_packer
    import tlut_pkg::*;
#(
    parameter int unsigned  DIM_C        = TLUT_DIM_C,
    parameter int unsigned  WEIGHT_WIDTH = TLUT_WEIGHT_WIDTH,
    localparam int unsigned LANE_W       = $clog2(DIM_C)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WEIGHT_WIDTH-1:0]              in_data,
    input  logic                                 in_last,
    output logic                                 vec_valid,
    input  logic                                 vec_ready,
    output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   vec_data,
    output logic                                 vec_short,
    output logic [LANE_W-1:0]                    lane_cnt
);

    typedef logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] vec_t;

    localparam logic [LANE_W-1:0] LastLane = LANE_W'(DIM_C - 1);

    state_e            state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    vec_t              fill_q, fill_d;
    logic              short_q, short_d;

    logic accept;
    logic last_beat;
    logic slot_free;
    logic load;
    logic load_short;
    vec_t load_data;

    // Lanes above the final written lane read as zero, so stale fill contents never leak.
    function automatic vec_t mask_lanes(input vec_t v, input logic [LANE_W-1:0] fin);
        vec_t m;
        for (int unsigned i = 0; i < DIM_C; i++) begin
            m[i] = (i > 32'(fin)) ? '0 : v[i];
        end
        return m;
    endfunction

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign last_beat = in_last || (lane_q == LastLane);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        fill_d     = fill_q;
        short_d    = short_q;
        load       = 1'b0;
        load_short = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    fill_d[lane_q] = in_data;
                    if (last_beat) begin
                        short_d = in_last && (lane_q != LastLane);
                        if (slot_free) begin
                            load       = 1'b1;
                            load_short = short_d;
                            lane_d     = '0;
                        end else begin
                            // lane_q is kept as the final-lane index of the held vector
                            state_d = HOLD;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_short = short_q;
                    lane_d     = '0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        load_data = mask_lanes(fill_d, lane_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            lane_q  <= '0;
            fill_q  <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            fill_q  <= fill_d;
            short_q <= short_d;
        end
    end

    assign lane_cnt = lane_q;

    weight_vec_slot #(
        .DIM_C        (DIM_C),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .load_short (load_short),
        .slot_free  (slot_free),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .vec_short  (vec_short)
    );

endmodule

// File: tb/tb_weight_stream_packer.sv
// Self-checking bench for weight_stream_packer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_weight_stream_packer;

    localparam int unsigned DC = 4;
    localparam int unsigned WW = 8;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WW-1:0]           in_data;
    logic                    in_last;
    logic                    vec_valid;
    logic                    vec_ready;
    logic [DC-1:0][WW-1:0]   vec_data;
    logic                    vec_short;
    logic [1:0]              lane_cnt;

    weight_stream_packer #(
        .DIM_C        (DC),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_short (vec_short),
        .lane_cnt  (lane_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected vectors in delivery order, built from the packing rules.
    typedef struct {
        logic [31:0] v;
        logic        s;
    } exp_t;

    exp_t     exp_q[$];
    logic [7:0] m_buf[DC];
    int       m_lane    = 0;
    bit       mon_en    = 0;
    bit       prev_hold = 0;
    logic [31:0] prev_data;
    logic     prev_short;
    int       delivered = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("vec_valid_model", vec_valid, exp_q.size() > 0);
            chk("in_ready_model", in_ready, exp_q.size() < 2);
            if (exp_q.size() < 2) chk("lane_cnt_model", lane_cnt, m_lane);
            if (prev_hold) begin
                chk("stable_valid", vec_valid, 1'b1);
                chk("stable_data", vec_data, prev_data);
                chk("stable_short", vec_short, prev_short);
            end
            prev_hold  = vec_valid && !vec_ready;
            prev_data  = vec_data;
            prev_short = vec_short;
            if (vec_valid && vec_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("deliver_data", vec_data, e.v);
                chk("deliver_short", vec_short, e.s);
                delivered++;
            end
            if (in_valid && in_ready) begin
                m_buf[m_lane] = in_data;
                if (m_lane == DC - 1 || in_last) begin
                    e.v = '0;
                    for (int k = 0; k <= m_lane; k++) e.v[8*k +: 8] = m_buf[k];
                    e.s = in_last && (m_lane != DC - 1);
                    exp_q.push_back(e);
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                chk("beat_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en   = 0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("rst_vec_valid", vec_valid, 1'b0);
        chk("rst_vec_data", vec_data, 32'h0);
        chk("rst_vec_short", vec_short, 1'b0);
        chk("rst_lane_cnt", lane_cnt, 2'd0);
        exp_q.delete();
        m_lane    = 0;
        prev_hold = 0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        int          n;
        logic [31:0] beats;
        logic        use_last;
        logic [31:0] exp_vec;
        logic        exp_short;
    } vcase_t;

    vcase_t cases[5];

    initial begin
        int w;
        int stalls;
        int d0;

        cases[0] = '{4, 32'h44332211, 1'b1, 32'h44332211, 1'b0};
        cases[1] = '{2, 32'hEEEEA2A1, 1'b1, 32'h0000A2A1, 1'b1};
        cases[2] = '{1, 32'hEEEEEE5A, 1'b1, 32'h0000005A, 1'b1};
        cases[3] = '{4, 32'h04030201, 1'b0, 32'h04030201, 1'b0};
        cases[4] = '{3, 32'hEECCBBAA, 1'b1, 32'h00CCBBAA, 1'b1};

        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        vec_ready = 1'b1;
        do_reset();

        // Directed vectors with an always-ready consumer.
        for (int c = 0; c < 5; c++) begin
            for (int b = 0; b < cases[c].n; b++) begin
                send_beat(cases[c].beats[8*b +: 8], cases[c].use_last && (b == cases[c].n - 1), w);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("tbl_valid", vec_valid, 1'b1);
            chk("tbl_data", vec_data, cases[c].exp_vec);
            chk("tbl_short", vec_short, cases[c].exp_short);
            chk("tbl_lane0", lane_cnt, 2'd0);
            step();
            chk("tbl_pulse", vec_valid, 1'b0);
        end

        // Backpressure: two vectors stack up, then drain on consecutive cycles.
        vec_ready = 1'b0;
        stalls    = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h11 + 8'(i), 1'b0, w);
            stalls += w;
        end
        in_valid = 1'b0;
        chk("bp_no_stall", stalls, 0);
        repeat (3) step();
        chk("bp_slot_data", vec_data, 32'h14131211);
        chk("bp_hold_ready", in_ready, 1'b0);
        chk("bp_hold_lane", lane_cnt, 2'd3);
        vec_ready = 1'b1;
        step();
        chk("bp_second_valid", vec_valid, 1'b1);
        chk("bp_second_data", vec_data, 32'h18171615);
        chk("bp_ready_back", in_ready, 1'b1);
        step();
        chk("bp_drained", vec_valid, 1'b0);

        // Full throughput.
        stalls = 0;
        d0     = delivered;
        for (int i = 0; i < 40; i++) begin
            send_beat(8'($urandom), 1'b0, w);
            stalls += w;
        end
        in_valid = 1'b0;
        step();
        chk("tp_no_stall", stalls, 0);
        chk("tp_vectors", delivered - d0, 10);

        // Simultaneous drain and completion.
        vec_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'h21 + 8'(i), 1'b0, w);
        for (int i = 0; i < 3; i++) send_beat(8'h31 + 8'(i), 1'b0, w);
        vec_ready = 1'b1;
        send_beat(8'h34, 1'b0, w);
        in_valid = 1'b0;
        chk("sim_data", vec_data, 32'h34333231);
        chk("sim_valid", vec_valid, 1'b1);
        chk("sim_no_hold", in_ready, 1'b1);
        chk("sim_lane0", lane_cnt, 2'd0);
        step();
        chk("sim_drained", vec_valid, 1'b0);

        // Reset mid-vector with a vector waiting in the slot.
        vec_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'h41 + 8'(i), 1'b0, w);
        send_beat(8'h51, 1'b0, w);
        send_beat(8'h52, 1'b0, w);
        in_valid = 1'b0;
        do_reset();
        vec_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'h61 + 8'(i), 1'b0, w);
        in_valid = 1'b0;
        chk("rst_clean_data", vec_data, 32'h64636261);
        chk("rst_clean_short", vec_short, 1'b0);
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            vec_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        vec_ready = 1'b1;
        repeat (4) step();
        chk("rand_all_delivered", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_stream_packer.md
Name: weight_stream_packer

Overview:
- Upstream neighbour of the DIM_C x WEIGHT_WIDTH weight pipeline register in the temporal-LUT multiplier array.
- Accepts weights one per beat on a valid/ready stream (memory/DMA side) and packs them into a DIM_C-lane vector.
- Presents each vector on a held valid/ready output, so the weight register loads one complete vector per transfer.
- One output holding slot plus one fill buffer: input keeps streaming while a finished vector waits for the consumer.

Parameters:
- DIM_C, 16, number of weight lanes per vector (>=2).
- WEIGHT_WIDTH, 8, bits per weight.
- LANE_W, $clog2(DIM_C), lane counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  WEIGHT_WIDTH  weight for current lane.
- in_last  input  1  final beat of vector; remaining lanes zero-filled.
- vec_valid  output  1  packed vector available.
- vec_ready  input  1  consumer takes vector when vec_valid && vec_ready.
- vec_data  output  DIM_C x WEIGHT_WIDTH  packed vector; lane 0 = first beat.
- vec_short  output  1  vector closed by in_last before lane DIM_C-1 (padded).
- lane_cnt  output  LANE_W  next lane to be written (debug/status).

Behaviour:
- Reset (async, rst_n=0): state=FILL, lane_cnt=0, fill buffer=0, vec_data=0, vec_valid=0, vec_short=0. in_ready=1 in the first cycle after release.
- States:
  - FILL: in_ready=1.
  - HOLD: in_ready=0. A vector is complete in the fill buffer and the output slot is occupied.
- Beat accept in FILL: fill_buf[lane_cnt] <= in_data.
- Vector completes on an accepted beat with lane_cnt==DIM_C-1 or in_last=1.
- Slot free at completion means vec_valid==0, or vec_valid && vec_ready in the same cycle. In that case:
  - next cycle: vec_data = completed vector, with lanes > final lane forced to 0.
  - vec_valid=1; vec_short = in_last && lane_cnt!=DIM_C-1.
  - lane_cnt<=0; stay in FILL.
- Slot occupied at completion: go to HOLD, keeping the fill buffer and final-lane index. In HOLD, the cycle after vec_valid && vec_ready, the held vector moves to the slot; lane_cnt<=0; return to FILL.
- Latency: closing beat accepted at edge t gives vec_valid high after edge t (visible cycle t+1).
- Throughput: one beat per clock sustained while the consumer is ready. No bubble between vectors.
- Slot drained with no replacement: vec_valid<=0 and vec_data keeps its value.
- vec_data and vec_short must stay stable while vec_valid && !vec_ready.
- in_last on lane DIM_C-1 behaves as a full vector, vec_short=0.
- in_last on lane 0 gives a vector with only lane 0 set, vec_short=1.
- lane_cnt wraps DIM_C-1 -> 0 only via completion. It never overflows.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- Reset mid-vector discards the partial fill and any held or slot vector. No output after reset until a new vector completes.
- Consumer asserting vec_ready with vec_valid=0 has no effect.

Decomposition:
- Shared package tlut_pkg holds:
  - DIM_C and WEIGHT_WIDTH defaults (matching DEF.sv values).
  - weight_t typedef (logic [WEIGHT_WIDTH-1:0]).
  - weight_vec_t typedef (weight_t [DIM_C-1:0]).
  - state enum {FILL, HOLD}.
- One sub-module, weight_vec_slot: the output holding register with valid/ready. It takes load/load_data/load_short, returns slot_free, and drives vec_* outputs. The top holds the FSM, lane counter, fill buffer and zero-fill mux.

Test Plan:
- DIM_C=4, WEIGHT_WIDTH=8, vec_ready=1. Stream 0x11,0x22,0x33,0x44 with last on 0x44 -> one cycle later vec_data={0x44,0x33,0x22,0x11}, vec_valid=1 for 1 cycle, vec_short=0.
- Short vector: 0xA1,0xA2 with in_last on 0xA2 -> vec_data={0,0,0xA2,0xA1}, vec_short=1. Next vector starts at lane 0.
- Backpressure: vec_ready=0, send 8 beats back-to-back ->
  - first vector held stable in the slot.
  - second vector completes and in_ready drops (HOLD).
  - raising vec_ready delivers vector 1, then vector 2 the cycle after, and in_ready returns to 1.
- Full throughput: 40 random beats continuous, vec_ready=1 -> 10 vectors, in_ready never low, all lanes match the scoreboard.
- Reset mid-vector: 2 beats in, rst_n pulsed low -> all outputs 0. Next 4 beats form a clean vector with no stale lanes.
- Simultaneous drain and completion: slot full, vec_ready=1 in the same cycle as the closing beat -> new vector in the slot the next cycle, no HOLD entry, no dropped vector.
